dmem_arbiter: RTL

- Shares the single data memory/IO port (128x16 data memory plus IO at 0xfff0/0xfffa) between two requesters.
- Requester 0 is the CPU datapath. Requester 1 is a loader/debug master.
- Sequences each access through a small FSM, drives the memory read/write enables and returns read data with a one-cycle ack pulse.
- Sits between the requesters and the data memory/IO block; the address map is passed through unchanged.

---
 rtl/dmem_arbiter_pkg.sv | 16 +
 rtl/dmem_arbiter_rr_pick2.sv | 24 ++
 rtl/dmem_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, requester IDs, IO addresses.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_AUX = 1'b1;

    localparam logic [15:0] IO_SW   = 16'hfff0;
    localparam logic [15:0] IO_DISP = 16'hfffa;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way request picker: round-robin against last_grant, or fixed priority to requester 0.
module rr_pick2
    import dmem_arbiter_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic gnt
);

    assign valid = req0 | req1;

    always_comb begin
        gnt = REQ_CPU;
        if (req0 && req1)
            gnt = (ROUND_ROBIN != 0) ? ~last_grant : REQ_CPU;
        else if (req1)
            gnt = REQ_AUX;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory/IO port between the CPU (requester 0) and a loader (requester 1),
// one access per IDLE -> SERVE -> DONE pass with a single-cycle ack.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int ROUND_ROBIN = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t state;
    logic   gnt;
    logic   last_grant;
    logic   pick_valid;
    logic   pick_gnt;
    logic   we_g;

    rr_pick2 #(.ROUND_ROBIN(ROUND_ROBIN)) u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .gnt        (pick_gnt)
    );

    assign we_g = (gnt == REQ_AUX) ? we1 : we0;
    assign busy = (state != ST_IDLE);

    // Memory port is only live during SERVE; reset in that cycle must not let a write through.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (state == ST_SERVE) begin
            mem_addr  = (gnt == REQ_AUX) ? addr1  : addr0;
            mem_wdata = (gnt == REQ_AUX) ? wdata1 : wdata0;
            mem_read  = ~we_g;
            mem_write = we_g & ~reset;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            gnt        <= REQ_CPU;
            last_grant <= REQ_AUX;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        gnt   <= pick_gnt;
                        state <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (!we_g) begin
                        if (gnt == REQ_AUX) rdata1 <= mem_rdata;
                        else                rdata0 <= mem_rdata;
                    end
                    if (gnt == REQ_AUX) ack1 <= 1'b1;
                    else                ack0 <= 1'b1;
                    last_grant <= gnt;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
